// File: rtl/msdap_pkg.sv
// MSDAP shared types for the output serializer slice.
// Holds word width, result buffer depth, FSM states and the stereo pair.
package msdap_pkg;

    localparam int MSDAP_OUT_W     = 40;
    localparam int MSDAP_OUT_DEPTH = 2;

    typedef enum logic {
        IDLE,
        SHIFT
    } oser_state_e;

    typedef struct packed {
        logic [MSDAP_OUT_W-1:0] L;
        logic [MSDAP_OUT_W-1:0] R;
    } result_pair_t;

endpackage

// File: rtl/msdap_result_fifo.sv
// Circular buffer of stereo result pairs between the FIR datapath
// and the serializer; pointers carry one wrap bit for full/empty.
module msdap_result_fifo
    import msdap_pkg::*;
#(
    parameter int DEPTH = MSDAP_OUT_DEPTH
) (
    input  logic         SCLK,
    input  logic         Reset_n,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  result_pair_t wrData,
    output result_pair_t rdData,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    result_pair_t mem [DEPTH];
    logic [AW:0]  wrPtr;
    logic [AW:0]  rdPtr;

    always_ff @(posedge SCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else if (clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + (AW+1)'(1);
            if (pop)  rdPtr <= rdPtr + (AW+1)'(1);
        end
    end

    always_ff @(posedge SCLK) begin
        if (push) mem[wrPtr[AW-1:0]] <= wrData;
    end

    assign rdData = mem[rdPtr[AW-1:0]];
    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW]) &&
                    (wrPtr[AW-1:0] == rdPtr[AW-1:0]);

endmodule

// File: rtl/msdap_out_serializer.sv
// MSDAP output stage: buffers stereo results and shifts them out MSB-first.
// Define MSDAP_OSER_DROP_CNT_EN to add the saturating DropCnt port.
module msdap_out_serializer
    import msdap_pkg::*;
#(
    parameter int OUT_W = MSDAP_OUT_W,
    parameter int DEPTH = MSDAP_OUT_DEPTH
) (
    input  logic             SCLK,
    input  logic             Reset_n,
    input  logic             Clear,
    input  logic             result_valid,
    input  logic [OUT_W-1:0] ResultL,
    input  logic [OUT_W-1:0] ResultR,
    output logic             OutputL,
    output logic             OutputR,
    output logic             OutReady,
`ifdef MSDAP_OSER_DROP_CNT_EN
    output logic [7:0]       DropCnt,
`endif
    output logic             Overflow
);

    localparam int CW = $clog2(OUT_W);
    localparam logic [CW-1:0] LAST = CW'(OUT_W - 1);

    oser_state_e  state;
    oser_state_e  nextState;
    logic [OUT_W-1:0] shL;
    logic [OUT_W-1:0] shR;
    logic [CW-1:0] bitCnt;
    logic          pop;
    logic          push;
    logic          drop;
    logic          full;
    logic          empty;
    result_pair_t  inPair;
    result_pair_t  headPair;

    assign inPair = '{L: ResultL, R: ResultR};

    msdap_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .SCLK    (SCLK),
        .Reset_n (Reset_n),
        .clear   (Clear),
        .push    (push),
        .pop     (pop),
        .wrData  (inPair),
        .rdData  (headPair),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        nextState = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    nextState = SHIFT;
                end
            end
            SHIFT: begin
                if (bitCnt == LAST) nextState = IDLE;
            end
        endcase
        if (Clear) begin
            nextState = IDLE;
            pop       = 1'b0;
        end
        // a same-cycle pop frees the slot the incoming pair needs
        push = result_valid && !Clear && (!full || pop);
        drop = result_valid && !Clear && full && !pop;
    end

    always_ff @(posedge SCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            shL      <= '0;
            shR      <= '0;
            bitCnt   <= '0;
            Overflow <= 1'b0;
        end else begin
            state <= nextState;
            if (Clear) begin
                shL      <= '0;
                shR      <= '0;
                bitCnt   <= '0;
                Overflow <= 1'b0;
            end else begin
                if (pop) begin
                    shL    <= headPair.L;
                    shR    <= headPair.R;
                    bitCnt <= '0;
                end else if (state == SHIFT) begin
                    // after OUT_W shifts the registers are zero again
                    shL    <= shL << 1;
                    shR    <= shR << 1;
                    bitCnt <= (bitCnt == LAST) ? '0 : bitCnt + CW'(1);
                end
                if (drop) Overflow <= 1'b1;
            end
        end
    end

`ifdef MSDAP_OSER_DROP_CNT_EN
    always_ff @(posedge SCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            DropCnt <= '0;
        end else if (Clear) begin
            DropCnt <= '0;
        end else if (drop && DropCnt != 8'hFF) begin
            DropCnt <= DropCnt + 8'd1;
        end
    end
`endif

    assign OutputL  = shL[OUT_W-1];
    assign OutputR  = shR[OUT_W-1];
    assign OutReady = (state == SHIFT);

endmodule

// File: tb/tb_msdap_out_serializer.sv
// Directed bench for msdap_out_serializer: a serial sink rebuilds each
// frame on the falling edge and frames are compared to hand-set words.
module tb_msdap_out_serializer;

    logic        SCLK = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Clear = 1'b0;
    logic        result_valid = 1'b0;
    logic [39:0] ResultL = '0;
    logic [39:0] ResultR = '0;
    logic        OutputL;
    logic        OutputR;
    logic        OutReady;
    logic        Overflow;
`ifdef MSDAP_OSER_DROP_CNT_EN
    logic [7:0]  DropCnt;
`endif

    always #5 SCLK = ~SCLK;

    msdap_out_serializer dut (
        .SCLK         (SCLK),
        .Reset_n      (Reset_n),
        .Clear        (Clear),
        .result_valid (result_valid),
        .ResultL      (ResultL),
        .ResultR      (ResultR),
        .OutputL      (OutputL),
        .OutputR      (OutputR),
        .OutReady     (OutReady),
`ifdef MSDAP_OSER_DROP_CNT_EN
        .DropCnt      (DropCnt),
`endif
        .Overflow     (Overflow)
    );

    typedef struct {
        logic [39:0] L;
        logic [39:0] R;
        int          len;
        int          gap;
    } frame_t;

    localparam logic [39:0] A_L = 40'h12_3456_789A;
    localparam logic [39:0] A_R = 40'hA5_A5A5_A5A5;
    localparam logic [39:0] B_L = 40'hC0_FFEE_0011;
    localparam logic [39:0] B_R = 40'h01_0203_0405;
    localparam logic [39:0] C_L = 40'h7F_FFFF_FFFF;
    localparam logic [39:0] C_R = 40'h80_0000_0000;
    localparam logic [39:0] D_L = 40'h5A_5A5A_5A5A;
    localparam logic [39:0] D_R = 40'hDE_ADBE_EF01;

    frame_t      frames[$];
    logic [39:0] capL = '0;
    logic [39:0] capR = '0;
    int          nBits = 0;
    int          gapCnt = 1000;
    int          curGap = 0;
    int          idleBits = 0;
    int          nChecks = 0;
    int          nPass = 0;

    always @(negedge SCLK) begin
        frame_t f;
        if (OutReady) begin
            if (nBits == 0) curGap = gapCnt;
            capL = {capL[38:0], OutputL};
            capR = {capR[38:0], OutputR};
            nBits++;
        end else begin
            if (nBits != 0) begin
                f.L = capL;
                f.R = capR;
                f.len = nBits;
                f.gap = curGap;
                frames.push_back(f);
                nBits = 0;
                gapCnt = 0;
            end
            gapCnt++;
            if (OutputL || OutputR) idleBits++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic strobe(input logic [39:0] l, input logic [39:0] r);
        result_valid = 1'b1;
        ResultL = l;
        ResultR = r;
        @(posedge SCLK);
        #1 result_valid = 1'b0;
    endtask

    task automatic waitFrames(input int n, input string tag);
        int k = 0;
        while (frames.size() < n && k < 400) begin
            @(negedge SCLK);
            k++;
        end
        check(tag, 64'(frames.size() >= n), 64'd1);
        @(posedge SCLK);
        #1;
    endtask

    task automatic waitReady(input logic lvl, input string tag);
        int k = 0;
        do begin
            @(negedge SCLK);
            k++;
        end while (OutReady !== lvl && k < 200);
        check(tag, 64'(OutReady), 64'(lvl));
    endtask

    task automatic checkFrame(input string tag, input logic [39:0] l,
                              input logic [39:0] r, input int gap);
        frame_t f;
        if (frames.size() == 0) begin
            check({tag, " present"}, 64'd0, 64'd1);
        end else begin
            f = frames.pop_front();
            check({tag, " L"}, 64'(f.L), 64'(l));
            check({tag, " R"}, 64'(f.R), 64'(r));
            check({tag, " len"}, 64'(f.len), 64'd40);
            if (gap >= 0) check({tag, " gap"}, 64'(f.gap), 64'(gap));
        end
    endtask

    task automatic truncLen(input string tag, input int len);
        frame_t f;
        if (frames.size() == 0) begin
            check({tag, " present"}, 64'd0, 64'd1);
        end else begin
            f = frames.pop_front();
            check({tag, " len"}, 64'(f.len), 64'(len));
        end
    endtask

    initial begin
        // reset, with a strobe while held
        @(posedge SCLK);
        #1 result_valid = 1'b1;
        ResultL = '1;
        ResultR = '1;
        @(negedge SCLK);
        check("rst outs", 64'({OutReady, OutputL, OutputR, Overflow}), 64'd0);
        @(posedge SCLK);
        #1 result_valid = 1'b0;
        repeat (2) @(posedge SCLK);
        #1 Reset_n = 1'b1;
        repeat (6) @(posedge SCLK);
        #1;
        check("post-rst ready", 64'(OutReady), 64'd0);
        check("post-rst frames", 64'(frames.size()), 64'd0);

        // single word and latency
        strobe(40'h80_0000_0001, 40'hFF_FFFF_FFFE);
        @(negedge SCLK);
        check("lat t+1", 64'(OutReady), 64'd0);
        @(negedge SCLK);
        check("lat t+2", 64'(OutReady), 64'd1);
        check("msb L", 64'(OutputL), 64'd1);
        check("msb R", 64'(OutputR), 64'd1);
        waitFrames(1, "single wait");
        checkFrame("single", 40'h80_0000_0001, 40'hFF_FFFF_FFFE, -1);
        check("single ovf", 64'(Overflow), 64'd0);

        // back-to-back
        strobe(A_L, A_R);
        strobe(B_L, B_R);
        strobe(C_L, C_R);
        waitFrames(3, "b2b wait");
        checkFrame("b2b A", A_L, A_R, -1);
        checkFrame("b2b B", B_L, B_R, 1);
        checkFrame("b2b C", C_L, C_R, 1);
        check("b2b ovf", 64'(Overflow), 64'd0);

        // overflow
        strobe(A_L, A_R);
        strobe(B_L, B_R);
        strobe(C_L, C_R);
        strobe(D_L, D_R);
        waitFrames(3, "ovf wait");
        repeat (60) @(posedge SCLK);
        #1;
        check("ovf frames", 64'(frames.size()), 64'd3);
        check("ovf flag", 64'(Overflow), 64'd1);
`ifdef MSDAP_OSER_DROP_CNT_EN
        check("dropcnt", 64'(DropCnt), 64'd1);
`endif
        checkFrame("ovf A", A_L, A_R, -1);
        checkFrame("ovf B", B_L, B_R, 1);
        checkFrame("ovf C", C_L, C_R, 1);
        Clear = 1'b1;
        @(posedge SCLK);
        #1 Clear = 1'b0;
        check("clear ovf", 64'(Overflow), 64'd0);
`ifdef MSDAP_OSER_DROP_CNT_EN
        check("clear dropcnt", 64'(DropCnt), 64'd0);
`endif

        // reset at bit 20
        strobe('1, '1);
        waitReady(1'b1, "rabort start");
        repeat (19) @(negedge SCLK);
        #1 check("rabort pre", 64'(OutputL), 64'd1);
        Reset_n = 1'b0;
        #1 check("rabort outs", 64'({OutReady, OutputL, OutputR}), 64'd0);
        @(posedge SCLK);
        #1 Reset_n = 1'b1;
        @(posedge SCLK);
        #1 truncLen("rabort trunc", 20);
        strobe(B_L, B_R);
        waitFrames(1, "rabort wait");
        checkFrame("rabort next", B_L, B_R, -1);

        // clear at bit 20
        strobe('1, '1);
        waitReady(1'b1, "cabort start");
        repeat (19) @(negedge SCLK);
        #1 Clear = 1'b1;
        #1 check("cabort hold", 64'(OutReady), 64'd1);
        @(posedge SCLK);
        #1 Clear = 1'b0;
        check("cabort outs", 64'({OutReady, OutputL, OutputR}), 64'd0);
        @(posedge SCLK);
        #1 truncLen("cabort trunc", 20);
        strobe(C_L, C_R);
        waitFrames(1, "cabort wait");
        checkFrame("cabort next", C_L, C_R, -1);

        // write on the pop edge while full
        strobe(A_L, A_R);
        strobe(B_L, B_R);
        strobe(C_L, C_R);
        waitReady(1'b1, "fpop start");
        waitReady(1'b0, "fpop gap");
        #1 result_valid = 1'b1;
        ResultL = D_L;
        ResultR = D_R;
        @(posedge SCLK);
        #1 result_valid = 1'b0;
        waitFrames(4, "fpop wait");
        checkFrame("fpop A", A_L, A_R, -1);
        checkFrame("fpop B", B_L, B_R, 1);
        checkFrame("fpop C", C_L, C_R, 1);
        checkFrame("fpop D", D_L, D_R, 1);
        check("fpop ovf", 64'(Overflow), 64'd0);
        check("idle quiet", 64'(idleBits), 64'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
